// File: rtl/contador_pkg.sv
// Shared types and defaults for the run/pause/load/direction counter controller.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LOAD  = 2'd3
  } estado_t;

  localparam int WIDTH_DEF      = 8;
  localparam int MAX_CUENTA_DEF = 255;
  localparam int PRESCALE_DEF   = 5;
  localparam int DEB_CYCLES_DEF = 4;

  // Start/stop toggles run and pause; a press during LOAD is dropped.
  function automatic estado_t estado_tras_start(estado_t e);
    estado_t s;
    case (e)
      IDLE:    s = RUN;
      RUN:     s = PAUSE;
      PAUSE:   s = RUN;
      default: s = e;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/secuenciador_contador_if.sv
// Button, load-value and counter-status bundle between the push-button panel and the controller.
interface secuenciador_contador_if
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             btn_start_stop;
  logic             btn_dir;
  logic             btn_load;
  logic [WIDTH-1:0] valor_carga;
  logic [WIDTH-1:0] cuenta;
  estado_t          estado;
  logic             dir;
  logic             tick;
  logic             wrap;

  modport master (
    output btn_start_stop, btn_dir, btn_load, valor_carga,
    input  cuenta, estado, dir, tick, wrap
  );

  modport slave (
    input  btn_start_stop, btn_dir, btn_load, valor_carga,
    output cuenta, estado, dir, tick, wrap
  );

endinterface

// File: rtl/secuenciador_contador_antirrebote.sv
// Raw push-button conditioner: two-flop synchronizer, debounce counter and a
// one-cycle pulse on each accepted press (releases give no pulse).
module antirrebote #(
  parameter int DEB_CYCLES = 4
) (
  input  logic reloj,
  input  logic reset,
  input  logic boton_i,
  output logic pulso_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEB_CYCLES - 1);

  logic          sinc1_q, sinc2_q;
  logic          nivel_q, nivel_d;
  logic          pulso_q, pulso_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d   = '0;
    nivel_d = nivel_q;
    pulso_d = 1'b0;
    if (sinc2_q != nivel_q) begin
      if (cnt_q == CNT_FIN) begin
        nivel_d = sinc2_q;
        pulso_d = sinc2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, exactly like the hardware it describes.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sinc1_q <= boton_i;
      sinc2_q <= sinc1_q;
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/secuenciador_contador.sv
// Run/pause/load/direction controller feeding the decimal digit splitter.
// Optional build macro CONTADOR_SATURA_EN: saturate at the bounds and pause instead of wrapping.
module secuenciador_contador
  import contador_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MAX_CUENTA = MAX_CUENTA_DEF,
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic                     reloj,
  input logic                     reset,
  secuenciador_contador_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_CUENTA);
  localparam logic [PW-1:0]    PRE_FIN = PW'(PRESCALE - 1);

  logic p_start, p_dir, p_load;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .reloj   (reloj),
    .reset   (reset),
    .boton_i (bus.btn_start_stop),
    .pulso_o (p_start)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .reloj   (reloj),
    .reset   (reset),
    .boton_i (bus.btn_dir),
    .pulso_o (p_dir)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .reloj   (reloj),
    .reset   (reset),
    .boton_i (bus.btn_load),
    .pulso_o (p_load)
  );

  estado_t          estado_q;
  logic [WIDTH-1:0] cuenta_q;
  logic [PW-1:0]    presc_q;
  logic             dir_q, tick_q, wrap_q;

  logic [WIDTH-1:0] paso_cuenta;
  logic             paso_limite;
  logic [WIDTH-1:0] carga_sat;

  // Next count for a step in the current direction; the comparisons keep the
  // arithmetic inside WIDTH bits even when MAX_CUENTA is the full range.
  always_comb begin
    paso_limite = 1'b0;
    paso_cuenta = cuenta_q;
    if (!dir_q) begin
      if (cuenta_q == MAX_W) paso_limite = 1'b1;
      else                   paso_cuenta = cuenta_q + 1'b1;
    end else begin
      if (cuenta_q == '0)    paso_limite = 1'b1;
      else                   paso_cuenta = cuenta_q - 1'b1;
    end
`ifndef CONTADOR_SATURA_EN
    if (paso_limite) paso_cuenta = dir_q ? MAX_W : '0;
`endif
  end

  assign carga_sat = (bus.valor_carga > MAX_W) ? MAX_W : bus.valor_carga;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      cuenta_q <= '0;
      presc_q  <= '0;
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;

      // Direction toggles independently; the step below still sees the old dir_q.
      if (p_dir) dir_q <= ~dir_q;

      if (p_load) begin
        estado_q <= LOAD;
        presc_q  <= '0;
      end else begin
        case (estado_q)
          IDLE: begin
            presc_q <= '0;
            if (p_start) estado_q <= estado_tras_start(estado_q);
          end
          RUN: begin
            if (p_start) begin
              estado_q <= estado_tras_start(estado_q);
            end else if (presc_q == PRE_FIN) begin
              presc_q  <= '0;
              cuenta_q <= paso_cuenta;
`ifdef CONTADOR_SATURA_EN
              if (paso_limite) begin
                wrap_q   <= 1'b1;
                estado_q <= PAUSE;
              end else begin
                tick_q <= 1'b1;
              end
`else
              tick_q <= 1'b1;
              wrap_q <= paso_limite;
`endif
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          PAUSE: begin
            if (p_start) estado_q <= estado_tras_start(estado_q);
          end
          LOAD: begin
            cuenta_q <= carga_sat;
            presc_q  <= '0;
            estado_q <= PAUSE;
          end
          default: estado_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cuenta = cuenta_q;
  assign bus.estado = estado_q;
  assign bus.dir    = dir_q;
  assign bus.tick   = tick_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_secuenciador_contador.sv
// Randomized bench for secuenciador_contador against an event-level reference model.
module tb_secuenciador_contador;
  import contador_pkg::*;

  localparam int W    = 8;
  localparam int MAXC = 255;
  localparam int PRE  = 5;
  localparam int DEB  = 4;

  logic reloj = 1'b0;
  logic reset = 1'b0;

  secuenciador_contador_if #(.WIDTH(W)) bus ();
  secuenciador_contador_if #(.WIDTH(9)) bus9 ();

  secuenciador_contador #(
    .WIDTH(W), .MAX_CUENTA(MAXC), .PRESCALE(PRE), .DEB_CYCLES(DEB)
  ) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  secuenciador_contador #(
    .WIDTH(9), .MAX_CUENTA(255), .PRESCALE(PRE), .DEB_CYCLES(DEB)
  ) dut9 (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus9)
  );

  always #5 reloj = ~reloj;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cuenta = 0;
  int m_estado = 0;
  int m_phase  = 0;
  bit m_dir    = 1'b0;
  bit m_tick   = 1'b0;
  bit m_wrap   = 1'b0;
  int edge_n   = 0;
  int ev_ss[$];
  int ev_dir[$];
  int ev_ld[$];
  int rel_at[4];

  // Press events take effect at the edge given by the button latency rule.
  always @(posedge reloj or posedge reset) begin : modelo
    int nxt;
    bit e_ss, e_dir, e_ld, d_old;
    if (reset) begin
      m_cuenta = 0; m_estado = 0; m_phase = 0;
      m_dir = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
      edge_n = 0;
      ev_ss.delete(); ev_dir.delete(); ev_ld.delete();
    end else begin
      edge_n++;
      e_ss  = (ev_ss.size()  > 0) && (ev_ss[0]  == edge_n);
      e_dir = (ev_dir.size() > 0) && (ev_dir[0] == edge_n);
      e_ld  = (ev_ld.size()  > 0) && (ev_ld[0]  == edge_n);
      if (e_ss)  void'(ev_ss.pop_front());
      if (e_dir) void'(ev_dir.pop_front());
      if (e_ld)  void'(ev_ld.pop_front());
      m_tick = 1'b0;
      m_wrap = 1'b0;
      d_old  = m_dir;
      if (e_dir) m_dir = !m_dir;
      if (e_ld) begin
        m_estado = 3;
        m_phase  = 0;
      end else if (m_estado == 0) begin
        m_phase = 0;
        if (e_ss) m_estado = 1;
      end else if (m_estado == 1) begin
        if (e_ss) m_estado = 2;
        else begin
          m_phase = (m_phase + 1) % PRE;
          if (m_phase == 0) begin
            nxt = d_old ? m_cuenta - 1 : m_cuenta + 1;
            if (nxt < 0 || nxt > MAXC) begin
`ifdef CONTADOR_SATURA_EN
              m_wrap   = 1'b1;
              m_estado = 2;
`else
              m_cuenta = d_old ? MAXC : 0;
              m_tick   = 1'b1;
              m_wrap   = 1'b1;
`endif
            end else begin
              m_cuenta = nxt;
              m_tick   = 1'b1;
            end
          end
        end
      end else if (m_estado == 2) begin
        if (e_ss) m_estado = 1;
      end else begin
        m_cuenta = (int'(bus.valor_carga) > MAXC) ? MAXC : int'(bus.valor_carga);
        m_phase  = 0;
        m_estado = 2;
      end
    end
  end

  // Automatic button release after the requested number of sampled edges.
  always @(negedge reloj) begin
    if (bus.btn_start_stop && edge_n >= rel_at[0]) bus.btn_start_stop = 1'b0;
    if (bus.btn_dir        && edge_n >= rel_at[1]) bus.btn_dir        = 1'b0;
    if (bus.btn_load       && edge_n >= rel_at[2]) bus.btn_load       = 1'b0;
    if (bus9.btn_load      && edge_n >= rel_at[3]) bus9.btn_load      = 1'b0;
  end

  function automatic logic [12:0] dut_vec();
    return {bus.cuenta, bus.estado, bus.dir, bus.tick, bus.wrap};
  endfunction

  function automatic logic [12:0] ref_vec();
    return {W'(m_cuenta), 2'(m_estado), m_dir, m_tick, m_wrap};
  endfunction

  // mask bit0 start_stop, bit1 dir, bit2 load; call just after a falling edge.
  task automatic press(input bit [2:0] mask, input int hold);
    int ev;
    ev = edge_n + 1 + DEB + 2;
    if (mask[0]) begin
      bus.btn_start_stop = 1'b1; rel_at[0] = edge_n + hold;
      if (hold >= DEB) ev_ss.push_back(ev);
    end
    if (mask[1]) begin
      bus.btn_dir = 1'b1; rel_at[1] = edge_n + hold;
      if (hold >= DEB) ev_dir.push_back(ev);
    end
    if (mask[2]) begin
      bus.btn_load = 1'b1; rel_at[2] = edge_n + hold;
      if (hold >= DEB) ev_ld.push_back(ev);
    end
  endtask

  task automatic test_reset();
    bus.btn_start_stop = 1'b0; bus.btn_dir = 1'b0; bus.btn_load = 1'b0;
    bus.valor_carga = '0;
    bus9.btn_start_stop = 1'b0; bus9.btn_dir = 1'b0; bus9.btn_load = 1'b0;
    bus9.valor_carga = '0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL reset_async: got %h want 0", dut_vec());
    end
    total++;
    if (bus9.cuenta !== 9'd0) begin
      bad++; $display("FAIL reset_async9: got %0d want 0", bus9.cuenta);
    end
    repeat (3) @(negedge reloj);
    reset = 1'b0;
    repeat (100) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL reset_idle: got %h want %h", dut_vec(), ref_vec());
      end
    end
  endtask

  task automatic test_start();
    int n0;
    @(negedge reloj);
    press(3'b001, 10);
    n0 = edge_n + 1;
    repeat (40) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL start: got %h want %h", dut_vec(), ref_vec());
      end
      if (edge_n == n0 + 5) begin
        total++;
        if (bus.estado !== IDLE) begin
          bad++; $display("FAIL start_early: got %0d want 0", bus.estado);
        end
      end
      if (edge_n == n0 + 6) begin
        total++;
        if (bus.estado !== RUN) begin
          bad++; $display("FAIL start_latency: got %0d want 1", bus.estado);
        end
      end
    end
  endtask

  task automatic test_load_wrap();
    int n0, seen;
    @(negedge reloj);
    bus.valor_carga = 8'd250;
    press(3'b100, 6);
    n0 = edge_n + 1;
    repeat (20) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL load: got %h want %h", dut_vec(), ref_vec());
      end
      if (edge_n == n0 + 6) begin
        total++;
        if (bus.estado !== LOAD) begin
          bad++; $display("FAIL load_state: got %0d want 3", bus.estado);
        end
      end
      if (edge_n == n0 + 7) begin
        total++;
        if ({bus.estado, bus.cuenta} !== {PAUSE, 8'd250}) begin
          bad++; $display("FAIL load_value: got %0d/%0d want 2/250", bus.estado, bus.cuenta);
        end
      end
    end
    press(3'b001, 6);
    seen = 0;
    repeat (60) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL run_up: got %h want %h", dut_vec(), ref_vec());
      end
      if (bus.wrap === 1'b1) seen++;
    end
    total++;
    if (seen !== 1) begin
      bad++; $display("FAIL wrap_count: got %0d want 1", seen);
    end
  endtask

  task automatic test_clamp();
    int n0;
    @(negedge reloj);
    bus9.valor_carga = 9'd300;
    bus9.btn_load = 1'b1;
    rel_at[3] = edge_n + 6;
    n0 = edge_n + 1;
    repeat (16) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL clamp_main: got %h want %h", dut_vec(), ref_vec());
      end
      if (edge_n == n0 + 6) begin
        total++;
        if (bus9.estado !== LOAD) begin
          bad++; $display("FAIL clamp_state: got %0d want 3", bus9.estado);
        end
      end
      if (edge_n == n0 + 7) begin
        total++;
        if ({bus9.estado, bus9.cuenta} !== {PAUSE, 9'd255}) begin
          bad++; $display("FAIL clamp_value: got %0d/%0d want 2/255", bus9.estado, bus9.cuenta);
        end
      end
    end
  endtask

  task automatic test_dir_wrap();
    int seen;
    logic [W-1:0] c_at;
    logic t_at;
    estado_t e_at;
    @(negedge reloj);
    bus.valor_carga = 8'd0;
    press(3'b100, 6);
    repeat (16) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL dir_load0: got %h want %h", dut_vec(), ref_vec());
      end
    end
    press(3'b010, 6);
    repeat (16) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL dir_press: got %h want %h", dut_vec(), ref_vec());
      end
    end
    press(3'b001, 6);
    seen = 0; c_at = '0; t_at = 1'b0; e_at = IDLE;
    repeat (14) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL dir_run: got %h want %h", dut_vec(), ref_vec());
      end
      if (bus.wrap === 1'b1) begin
        seen++; c_at = bus.cuenta; t_at = bus.tick; e_at = bus.estado;
      end
    end
    total++;
`ifdef CONTADOR_SATURA_EN
    if (seen !== 1 || c_at !== 8'd0 || t_at !== 1'b0 || e_at !== PAUSE) begin
      bad++; $display("FAIL down_sat: got n=%0d c=%0d t=%0d e=%0d want n=1 c=0 t=0 e=2",
                      seen, c_at, t_at, e_at);
    end
`else
    if (seen !== 1 || c_at !== 8'd255 || t_at !== 1'b1) begin
      bad++; $display("FAIL down_wrap: got n=%0d c=%0d t=%0d want n=1 c=255 t=1",
                      seen, c_at, t_at);
    end
`endif
  endtask

  task automatic test_glitch();
    estado_t pre;
    @(negedge reloj);
    pre = bus.estado;
    press(3'b001, 3);
    repeat (20) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL glitch: got %h want %h", dut_vec(), ref_vec());
      end
    end
    total++;
    if (bus.estado !== pre) begin
      bad++; $display("FAIL glitch_state: got %0d want %0d", bus.estado, pre);
    end
  endtask

  task automatic test_coincide();
    int n0;
    logic [W-1:0] v;
    @(negedge reloj);
    v = W'($urandom_range(0, 255));
    bus.valor_carga = v;
    press(3'b101, 6);
    n0 = edge_n + 1;
    repeat (20) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL coincide: got %h want %h", dut_vec(), ref_vec());
      end
      if (edge_n == n0 + 6) begin
        total++;
        if (bus.estado !== LOAD) begin
          bad++; $display("FAIL coincide_load: got %0d want 3", bus.estado);
        end
      end
      if (edge_n == n0 + 7) begin
        total++;
        if ({bus.estado, bus.cuenta} !== {PAUSE, v}) begin
          bad++; $display("FAIL coincide_pause: got %0d/%0d want 2/%0d", bus.estado, bus.cuenta, v);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold;
    bit [2:0] mask;
    for (int it = 0; it < 40; it++) begin
      @(negedge reloj);
      bus.valor_carga = W'($urandom_range(0, 255));
      mask = 3'($urandom_range(1, 7));
      hold = $urandom_range(DEB, DEB + 4);
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(1, DEB - 1);
      press(mask, hold);
      repeat (hold + $urandom_range(10, 16)) begin
        @(negedge reloj);
        total++;
        if (dut_vec() !== ref_vec()) begin
          bad++; $display("FAIL random_%0d: got %h want %h", it, dut_vec(), ref_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge reloj);
    if (m_estado != 1) press(3'b001, 6);
    repeat (14) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL pre_reset: got %h want %h", dut_vec(), ref_vec());
      end
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL reset_mid: got %h want 0", dut_vec());
    end
    total++;
    if ({bus9.cuenta, bus9.estado} !== 11'd0) begin
      bad++; $display("FAIL reset_mid9: got %0d/%0d want 0/0", bus9.cuenta, bus9.estado);
    end
    @(negedge reloj);
    reset = 1'b0;
    repeat (20) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL post_reset: got %h want %h", dut_vec(), ref_vec());
      end
    end
    press(3'b001, 6);
    repeat (24) begin
      @(negedge reloj);
      total++;
      if (dut_vec() !== ref_vec()) begin
        bad++; $display("FAIL restart: got %h want %h", dut_vec(), ref_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_load_wrap();
    test_clamp();
    test_dir_wrap();
    test_glitch();
    test_coincide();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
